ifid_skid_reg: RTL and testbench

Parametrised IF/ID pipeline boundary register with valid/ready handshaking, a two-entry skid buffer, and synchronous flush. Sits between the fetch stage (PC and instruction memory output) and the decode stage. It replaces the plain always-enabled IF/ID latch so that decode backpressure and branch/jump squashes are handled at the boundary. Full throughput is one instruction per cycle. `in_ready` is a registered signal, so no combinational path runs from `out_ready` to `in_ready`.

---
 rtl/ifid_skid_reg.sv | 157 +++++++++++++++
 tb/tb_ifid_skid_reg.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifid_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : ifid_skid_reg
// Brief    : IF/ID pipeline boundary register with a valid/ready handshake,
//            a two-entry skid buffer and a synchronous flush. Optional
//            stall/flush performance counters are enabled by defining
//            IFID_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ifid_skid_reg #(
    parameter int                PC_W     = 32,
    parameter int                INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}}
`ifdef IFID_PERF_CNT_EN
    ,
    parameter int                CNT_W    = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [INST_W-1:0] inst_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   pc_out,
    output logic [INST_W-1:0] inst_out,
    output logic [1:0]        occupancy
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [1:0]          r_occ;
    logic [PC_W-1:0]     r_main_pc;
    logic [INST_W-1:0]   r_main_inst;
    logic [PC_W-1:0]     r_skid_pc;
    logic [INST_W-1:0]   r_skid_inst;

    logic                w_in_fire;
    logic                w_out_fire;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // Handshake flags and occupancy are stored next to the state so every
    // output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occ       <= 2'd0;
            r_main_pc   <= '0;
            r_main_inst <= NOP_INST;
            r_skid_pc   <= '0;
            r_skid_inst <= '0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_occ       <= 2'd0;
            r_main_inst <= NOP_INST;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                        r_occ       <= 2'd1;
                        r_main_pc   <= pc_in;
                        r_main_inst <= inst_in;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main_pc   <= pc_in;
                        r_main_inst <= inst_in;
                    end else if (w_in_fire) begin
                        r_state     <= ST_TWO;
                        r_in_ready  <= 1'b0;
                        r_occ       <= 2'd2;
                        r_skid_pc   <= pc_in;
                        r_skid_inst <= inst_in;
                    end else if (w_out_fire) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                        r_occ       <= 2'd0;
                        r_main_inst <= NOP_INST;
                    end
                end
                ST_TWO: begin
                    if (w_out_fire) begin
                        r_state     <= ST_ONE;
                        r_in_ready  <= 1'b1;
                        r_occ       <= 2'd1;
                        r_main_pc   <= r_skid_pc;
                        r_main_inst <= r_skid_inst;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_occ       <= 2'd0;
                    r_main_inst <= NOP_INST;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign occupancy = r_occ;
    assign pc_out    = r_main_pc;
    assign inst_out  = r_main_inst;

`ifdef IFID_PERF_CNT_EN
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Saturating counters; only reset clears them so flushes stay visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_out_valid && !out_ready && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (flush && (r_state != ST_EMPTY) && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifid_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifid_skid_reg
// Brief    : Self-checking bench for ifid_skid_reg: queue-based reference
//            model compared every cycle plus directed literal checks.
//            Counter checks are active when IFID_PERF_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifid_skid_reg;

    localparam int          PC_W  = 32;
    localparam int          INST_W = 32;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          CNT_W = 16;
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   pc_in;
    logic [INST_W-1:0] inst_in;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   pc_out;
    logic [INST_W-1:0] inst_out;
    logic [1:0]        occupancy;
`ifdef IFID_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ifid_skid_reg #(
        .PC_W     (PC_W),
        .INST_W   (INST_W),
        .NOP_INST (NOP)
`ifdef IFID_PERF_CNT_EN
        ,
        .CNT_W    (CNT_W)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pc_in     (pc_in),
        .inst_in   (inst_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pc_out    (pc_out),
        .inst_out  (inst_out),
        .occupancy (occupancy)
`ifdef IFID_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two entries
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } ent_t;

    ent_t             mq[$];
    logic [PC_W-1:0]  m_last_pc = '0;
    logic [CNT_W-1:0] m_stall   = '0;
    logic [CNT_W-1:0] m_flush   = '0;
    bit               m_live    = 1'b0;

    always @(posedge clk) begin : model
        bit ifire;
        bit ofire;
        ent_t e;
        ifire = in_valid && (mq.size() < 2);
        ofire = (mq.size() > 0) && out_ready;
        if (rst) begin
            mq.delete();
            m_last_pc = '0;
            m_stall   = '0;
            m_flush   = '0;
            m_live    = 1'b1;
        end else begin
            if ((mq.size() > 0) && !out_ready && (m_stall != CMAX)) m_stall = m_stall + 1'b1;
            if (flush) begin
                if ((mq.size() > 0) && (m_flush != CMAX)) m_flush = m_flush + 1'b1;
                mq.delete();
            end else begin
                if (ofire) void'(mq.pop_front());
                if (ifire) begin
                    e.pc   = pc_in;
                    e.inst = inst_in;
                    mq.push_back(e);
                end
            end
            if (mq.size() > 0) m_last_pc = mq[0].pc;
        end
    end

    always @(negedge clk) begin : compare
        if (m_live) begin
            chk("out_valid", out_valid, (mq.size() > 0));
            chk("in_ready", in_ready, (mq.size() < 2));
            chk("occupancy", occupancy, mq.size());
            chk("pc_out", pc_out, (mq.size() > 0) ? mq[0].pc : m_last_pc);
            chk("inst_out", inst_out, (mq.size() > 0) ? mq[0].inst : NOP);
`ifdef IFID_PERF_CNT_EN
            chk("stall_cnt", stall_cnt, m_stall);
            chk("flush_cnt", flush_cnt, m_flush);
`endif
        end
    end

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                        input logic ordy, input logic fl, input logic r);
        in_valid  = iv;
        pc_in     = pc;
        inst_in   = inst;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] pc, input logic ordy, input logic fl);
        step(1'b1, pc, inst_of(pc), ordy, fl, 1'b0);
    endtask

    task automatic idle(input logic ordy, input logic fl);
        step(1'b0, 32'h0, 32'h0, ordy, fl, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        pc_in = '0; inst_in = '0;

        // Reset / idle
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_pc_out", pc_out, 0);
        chk("rst_inst_out", inst_out, NOP);
        chk("rst_occ", occupancy, 0);

        // Streaming with decode always ready
        step(1'b1, 32'h100, 32'h8C01_0004, 1'b1, 1'b0, 1'b0);
        chk("s0_pc", pc_out, 32'h100);
        chk("s0_inst", inst_out, 32'h8C01_0004);
        chk("s0_occ", occupancy, 1);
        step(1'b1, 32'h104, 32'h0022_1820, 1'b1, 1'b0, 1'b0);
        chk("s1_pc", pc_out, 32'h104);
        chk("s1_inst", inst_out, 32'h0022_1820);
        chk("s1_occ", occupancy, 1);
        step(1'b1, 32'h108, 32'hAC03_0008, 1'b1, 1'b0, 1'b0);
        chk("s2_pc", pc_out, 32'h108);
        chk("s2_inst", inst_out, 32'hAC03_0008);
        chk("s2_occ", occupancy, 1);
        idle(1'b1, 1'b0);
        chk("drain_valid", out_valid, 0);
        chk("drain_pc_kept", pc_out, 32'h108);
        chk("drain_inst_nop", inst_out, NOP);

        // Backpressure: out_ready low for three edges
        push(32'h100, 1'b1, 1'b0);
        push(32'h104, 1'b1, 1'b0);
        push(32'h108, 1'b0, 1'b0);
        chk("bp_occ2", occupancy, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_pc", pc_out, 32'h104);
        push(32'h10C, 1'b0, 1'b0);
        push(32'h10C, 1'b0, 1'b0);
        chk("bp_hold_occ", occupancy, 2);
        chk("bp_hold_pc", pc_out, 32'h104);
        push(32'h10C, 1'b1, 1'b0);
        chk("bp_rel_pc", pc_out, 32'h108);
        chk("bp_rel_rdy", in_ready, 1);
        chk("bp_rel_occ", occupancy, 1);
        push(32'h10C, 1'b1, 1'b0);
        chk("bp_last_pc", pc_out, 32'h10C);
        chk("bp_last_inst", inst_out, 32'hA000_010C);
        idle(1'b1, 1'b0);
        chk("bp_empty", out_valid, 0);

        // Flush while full with input presented
        push(32'h110, 1'b0, 1'b0);
        push(32'h114, 1'b0, 1'b0);
        chk("fl_full", occupancy, 2);
        push(32'h200, 1'b0, 1'b1);
        chk("fl_occ", occupancy, 0);
        chk("fl_valid", out_valid, 0);
        chk("fl_inst", inst_out, NOP);
        chk("fl_pc_kept", pc_out, 32'h110);

        // Flush in ONE while an input would otherwise be accepted
        push(32'h120, 1'b1, 1'b0);
        chk("fl1_pc", pc_out, 32'h120);
        push(32'h204, 1'b1, 1'b1);
        chk("fl1_occ", occupancy, 0);
        chk("fl1_rdy", in_ready, 1);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        chk("fl1_no_ghost", out_valid, 0);

        // Reset has priority over flush
        push(32'h130, 1'b0, 1'b0);
        push(32'h134, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("rp_pc", pc_out, 0);
        chk("rp_occ", occupancy, 0);
        chk("rp_inst", inst_out, NOP);
        chk("rp_rdy", in_ready, 1);
`ifdef IFID_PERF_CNT_EN
        chk("rp_flush_cnt", flush_cnt, 0);
        chk("rp_stall_cnt", stall_cnt, 0);

        // Counters
        push(32'h140, 1'b0, 1'b0);
        repeat (5) idle(1'b0, 1'b0);
        chk("cnt_stall5", stall_cnt, 5);
        idle(1'b1, 1'b1);
        push(32'h144, 1'b0, 1'b0);
        idle(1'b1, 1'b1);
        chk("cnt_stall_keep", stall_cnt, 5);
        chk("cnt_flush2", flush_cnt, 2);
        idle(1'b1, 1'b1);
        chk("cnt_flush_empty", flush_cnt, 2);
        push(32'h148, 1'b0, 1'b0);
        repeat (65535) idle(1'b0, 1'b0);
        chk("cnt_sat", stall_cnt, 16'hFFFF);
        idle(1'b0, 1'b0);
        chk("cnt_sat_hold", stall_cnt, 16'hFFFF);
`endif

        idle(1'b1, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
